// File: rtl/mul_pkg.sv
// Shared types for the pipelined HI/LO multiply unit.
// Operation codes, depth limit and operand extension helper.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_MULT  = 2'd0,
        MUL_MULTU = 2'd1,
        MUL_MADD  = 2'd2,
        MUL_MADDU = 2'd3
    } mul_op_t;

    localparam int MUL_MAX_STAGES = 16;

    // Extension bit placed above an operand's MSB:
    // sign copy for signed ops, zero for unsigned ops.
    function automatic logic mul_ext_bit(
        input mul_op_t op,
        input logic    msb
    );
        return msb & ~op[0];
    endfunction

endpackage

// File: rtl/mul_pipe_unit_if.sv
// Request/response handshake bundle of the multiply unit.
// master = issuing/consuming side, slave = the unit.
interface mul_pipe_unit_if
    import mul_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
);

    logic             in_valid;
    logic             in_ready;
    mul_op_t          in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2*W-1:0]   in_acc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b,
        output in_acc, in_tag, out_ready,
        input  in_ready, out_valid,
        input  out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  in_acc, in_tag, out_ready,
        output in_ready, out_valid,
        output out_result, out_tag
    );

endinterface

// File: rtl/mul_stage_reg.sv
// One pipeline stage register: valid, op, tag and data.
// Holds on !en; flush clears valid even while holding.
module mul_stage_reg
    import mul_pkg::*;
#(
    parameter int DW    = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  mul_op_t          in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    output mul_op_t          out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [DW-1:0]    out_data
);

    logic             valid_d, valid_q;
    mul_op_t          op_d, op_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [DW-1:0]    data_d, data_q;

    // Next state: load on enable, otherwise hold; flush wins.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (en) begin
            valid_d = in_valid;
            op_d    = in_op;
            tag_d   = in_tag;
            data_d  = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Stage state flops, cleared by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= MUL_MULT;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_tag   = tag_q;
    assign out_data  = data_q;

endmodule

// File: rtl/mul_pipe_unit.sv
// Fully pipelined signed/unsigned multiplier, STAGES deep.
// Define MUL_ACC_EN to build multiply-accumulate (ops 2/3).
module mul_pipe_unit
    import mul_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 6,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    mul_pipe_unit_if.slave  bus,
    output logic            busy
);

    localparam int PW = 2 * W;
`ifdef MUL_ACC_EN
    localparam int DW = 2 * PW;
`else
    localparam int DW = PW;
`endif

    logic                adv;
    logic                accept;
    mul_op_t             op0;
    logic signed [W:0]   ea;
    logic signed [W:0]   eb;
    logic signed [PW+1:0] full;
    logic [PW-1:0]       prod;
    logic [DW-1:0]       d0;

    logic [STAGES-1:0]   v;
    mul_op_t             op  [STAGES];
    logic [TAG_W-1:0]    tag [STAGES];
    logic [DW-1:0]       dat [STAGES-1];
    logic [PW-1:0]       res;
    logic                unused_bits;

    // Whole pipe moves unless a result is waiting on the consumer.
    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;
    assign accept       = bus.in_valid && adv && !flush;

    // Stage-1 product; accumulator rides along when enabled.
    always_comb begin
`ifdef MUL_ACC_EN
        op0 = bus.in_op;
`else
        op0 = mul_op_t'({1'b0, bus.in_op[0]});
`endif
        ea   = {mul_ext_bit(op0, bus.in_a[W-1]), bus.in_a};
        eb   = {mul_ext_bit(op0, bus.in_b[W-1]), bus.in_b};
        full = ea * eb;
        prod = full[PW-1:0];
`ifdef MUL_ACC_EN
        d0   = {bus.in_acc, prod};
`else
        d0   = prod;
`endif
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i < STAGES - 1) begin : g_mid
            logic             vin;
            mul_op_t          oin;
            logic [TAG_W-1:0] tin;
            logic [DW-1:0]    din;

            if (i == 0) begin : g_first
                assign vin = accept;
                assign oin = op0;
                assign tin = bus.in_tag;
                assign din = d0;
            end else begin : g_next
                assign vin = v[i-1];
                assign oin = op[i-1];
                assign tin = tag[i-1];
                assign din = dat[i-1];
            end

            mul_stage_reg #(
                .DW    (DW),
                .TAG_W (TAG_W)
            ) u_reg (
                .clk       (clk),
                .rst_n     (resetn),
                .en        (adv),
                .flush     (flush),
                .in_valid  (vin),
                .in_op     (oin),
                .in_tag    (tin),
                .in_data   (din),
                .out_valid (v[i]),
                .out_op    (op[i]),
                .out_tag   (tag[i]),
                .out_data  (dat[i])
            );
        end else begin : g_last
            logic [PW-1:0] sum;

`ifdef MUL_ACC_EN
            // Final-stage accumulate, wrapping modulo 2^(2W).
            always_comb begin
                sum = dat[i-1][PW-1:0];
                if (op[i-1][1]) begin
                    sum = sum + dat[i-1][DW-1:PW];
                end
            end
`else
            assign sum = dat[i-1];
`endif

            mul_stage_reg #(
                .DW    (PW),
                .TAG_W (TAG_W)
            ) u_reg (
                .clk       (clk),
                .rst_n     (resetn),
                .en        (adv),
                .flush     (flush),
                .in_valid  (v[i-1]),
                .in_op     (op[i-1]),
                .in_tag    (tag[i-1]),
                .in_data   (sum),
                .out_valid (v[i]),
                .out_op    (op[i]),
                .out_tag   (tag[i]),
                .out_data  (res)
            );
        end
    end

    assign bus.out_valid  = v[STAGES-1];
    assign bus.out_result = res;
    assign bus.out_tag    = tag[STAGES-1];
    assign busy           = |v;

    // Bits that exist only for width or for the other build.
`ifdef MUL_ACC_EN
    assign unused_bits = ^{full[PW+1:PW], op[STAGES-1]};
`else
    assign unused_bits = ^{full[PW+1:PW], op[STAGES-1],
                           bus.in_acc, bus.in_op[1]};
`endif

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Self-checking bench for mul_pipe_unit: directed cases
// plus randomized traffic against a queue reference model.
module tb_mul_pipe_unit;
    import mul_pkg::*;

    localparam int W      = 32;
    localparam int STAGES = 6;
    localparam int TAG_W  = 4;
`ifdef MUL_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    logic flush;
    logic busy;

    mul_pipe_unit_if #(.W(W), .TAG_W(TAG_W)) bus ();

    mul_pipe_unit #(
        .W      (W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string nm,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: exact product by plain arithmetic, then optional acc.
    function automatic logic [63:0] ref_mul(input logic [1:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [63:0] acc);
        logic [63:0] p;
        if (op[0]) p = {32'b0, a} * {32'b0, b};
        else       p = longint'($signed(a)) * longint'($signed(b));
        if (ACC_EN && op[1]) p = p + acc;
        return p;
    endfunction

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        int          acnt;
    } exp_t;

    exp_t q[$];
    int   adv_cnt = 0;
    int   n_fire  = 0;

    // Scoreboard: in-order results, tags, busy, ready and latency.
    always @(negedge clk) begin
        if (!resetn) begin
            q.delete();
        end else begin
            check("busy", busy, q.size() != 0);
            check("in_ready", bus.in_ready,
                  !(bus.out_valid && !bus.out_ready));
            if (!(bus.out_valid && !bus.out_ready)) adv_cnt++;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    check("result", bus.out_result, q[0].res);
                    check("tag", bus.out_tag, q[0].tag);
                    if (bus.out_ready) begin
                        check("latency", adv_cnt - q[0].acnt, STAGES);
                        void'(q.pop_front());
                        n_fire++;
                    end
                end
            end
            if (flush) begin
                q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                q.push_back('{ref_mul(bus.in_op, bus.in_a, bus.in_b,
                                      bus.in_acc),
                              bus.in_tag, adv_cnt});
            end
        end
    end

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mul_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] acc,
                         input logic [3:0] tg);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc;
        bus.in_tag   = tg;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 40);
    endtask

    task automatic count_out(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        at_pos();
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_left"}, q.size(), 0);
    endtask

    task automatic run_one(input string nm, input mul_op_t op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] acc, input logic [3:0] tg,
                           input logic [63:0] exp);
        int n;
        at_pos();
        drive(op, a, b, acc, tg);
        at_pos();
        bus.in_valid = 1'b0;
        wait_out(n);
        check({nm, "_lat"}, n, STAGES);
        check({nm, "_res"}, bus.out_result, exp);
        check({nm, "_tag"}, bus.out_tag, tg);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int f0;
        resetn        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = MUL_MULT;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_acc    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.out_result, 0);
        check("rst_tag", bus.out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        resetn        = 1'b1;
        bus.out_ready = 1'b1;

        run_one("mult", MUL_MULT, 32'hFFFF_FFFE, 32'd4, 64'd0, 4'd3,
                64'hFFFF_FFFF_FFFF_FFF8);
        run_one("multu", MUL_MULTU, 32'hFFFF_FFFE, 32'd4, 64'd0, 4'd5,
                64'h0000_0003_FFFF_FFF8);

        // back-to-back pair
        at_pos();
        drive(MUL_MULT, 32'd2, 32'd4, 64'd0, 4'd1);
        at_pos();
        drive(MUL_MULT, 32'd3, 32'd5, 64'd0, 4'd2);
        at_pos();
        bus.in_valid = 1'b0;
        wait_out(n);
        check("b2b_lat", n, STAGES - 1);
        check("b2b_res0", bus.out_result, 64'd8);
        check("b2b_tag0", bus.out_tag, 4'd1);
        @(negedge clk);
        check("b2b_valid1", bus.out_valid, 1);
        check("b2b_res1", bus.out_result, 64'd15);
        check("b2b_tag1", bus.out_tag, 4'd2);

        // stall with the pipe full
        at_pos();
        bus.out_ready = 1'b0;
        f0 = n_fire;
        for (int i = 0; i < STAGES + 2; i++) begin
            drive(MUL_MULTU, 32'(i + 1), 32'd7, 64'd0, 4'(i));
            at_pos();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", bus.in_ready, 0);
            check("stall_valid", bus.out_valid, 1);
            check("stall_res", bus.out_result, 64'd7);
            check("stall_tag", bus.out_tag, 4'd0);
        end
        drain("stall");
        check("stall_count", n_fire - f0, STAGES);

        // flush with four ops in flight
        at_pos();
        for (int i = 0; i < 4; i++) begin
            drive(MUL_MULT, 32'(i + 10), 32'(i + 1), 64'd0, 4'(i));
            at_pos();
        end
        drive(MUL_MULT, 32'd99, 32'd99, 64'd0, 4'd9);
        flush = 1'b1;
        at_pos();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        check("flush_valid", bus.out_valid, 0);
        count_out(STAGES + 4, cnt);
        check("flush_no_out", cnt, 0);
        run_one("post_flush", MUL_MULT, 32'd6, 32'hFFFF_FFF9, 64'd0,
                4'd7, 64'hFFFF_FFFF_FFFF_FFD6);

        // accumulate ops
        run_one("madd", MUL_MADD, 32'hFFFF_FFFF, 32'd3, 64'h10, 4'd4,
                ACC_EN ? 64'h0000_0000_0000_000D
                       : 64'hFFFF_FFFF_FFFF_FFFD);
        run_one("maddu", MUL_MADDU, 32'hFFFF_FFFF, 32'd3, 64'h10, 4'd6,
                ACC_EN ? 64'h0000_0003_0000_000D
                       : 64'h0000_0002_FFFF_FFFD);

        // randomized traffic with back-pressure and rare flushes
        for (int i = 0; i < 600; i++) begin
            at_pos();
            bus.in_valid  = $urandom_range(0, 9) < 7;
            bus.in_op     = mul_op_t'($urandom_range(0, 3));
            bus.in_a      = rnd32();
            bus.in_b      = rnd32();
            bus.in_acc    = {$urandom, $urandom};
            bus.in_tag    = 4'($urandom);
            bus.out_ready = $urandom_range(0, 9) < 7;
            flush         = $urandom_range(0, 49) == 0;
        end
        drain("rand");

        // asynchronous reset in the middle of a stalled stream
        at_pos();
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES + 1; i++) begin
            drive(MUL_MULT, 32'(i + 3), 32'd11, 64'd0, 4'(i + 1));
            at_pos();
        end
        bus.in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_result", bus.out_result, 0);
        check("mrst_tag", bus.out_tag, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        #2;
        resetn        = 1'b1;
        bus.out_ready = 1'b1;
        count_out(STAGES + 4, cnt);
        check("mrst_no_stale", cnt, 0);
        run_one("post_rst", MUL_MULTU, 32'd9, 32'd9, 64'd0, 4'd8,
                64'd81);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
